amiq_dcr_master_ctrl: RTL and testbench
=======================================

# amiq_dcr_master_ctrl

DCR bus master controller that converts a simple valid/ready request/response interface into protocol-compliant DCR read and write transfers. It sits directly upstream of the DCR bus interface and drives its command side: read, write, privileged, master_id, a_bus and d_bus_out. It consumes ack and d_bus_in from the bus and owns the master-side timeout, which timeout_wait can inhibit.

## Interface
Parameters:
- ADDR_WIDTH, 32: a_bus width, legal range 10..32; upper bus bits above ADDR_WIDTH are driven 0.
- DATA_WIDTH, 32: data width, max 32.
- MASTER_ID_WIDTH, 4: master ID width, max 4.
- TIMEOUT_CYCLES, 64: cycles without ack before the transfer is abandoned; 0 disables the timeout.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  bus clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when both are high
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  target address
- req_wdata  in  DATA_WIDTH  write data
- req_priv  in  1  privileged transfer
- req_master_id  in  MASTER_ID_WIDTH  issuing master
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when both are high
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts
- rsp_timeout  out  1  transfer ended by timeout
- read, write  out  1 each  DCR command strobes
- privileged  out  1  DCR privileged
- master_id  out  MASTER_ID_WIDTH  DCR master ID
- a_bus  out  ADDR_WIDTH  DCR address
- d_bus_out  out  DATA_WIDTH  DCR write data
- timeout_wait  in  1  slave inhibits the timeout counter
- ack  in  1  slave acknowledge
- d_bus_in  in  DATA_WIDTH  slave read data

## Operation
- FSM states:
  - IDLE: req_ready = !ack. This guarantees no command rises while ack is high.
  - CMD: the selected read or write strobe is asserted.
  - RSP: rsp_valid = 1.
- IDLE→CMD on req handshake. A request is captured into registers, and all DCR outputs are driven from those registers.
- During CMD:
  - a_bus, privileged and master_id are held constant.
  - d_bus_out is req_wdata for a write and 0 for a read.
  - read and write are never high together.
- Timeout counter:
  - Loaded with TIMEOUT_CYCLES-1 on accept.
  - Decrements in CMD when ack==0 and timeout_wait==0.
  - Holds at 0 and while timeout_wait==1.
- CMD→RSP on ack==1:
  - rsp_rdata is captured from d_bus_in for a read (0 for a write).
  - rsp_timeout = 0.
- CMD→RSP on ack==0 with counter==0 and TIMEOUT_CYCLES!=0:
  - rsp_timeout = 1 and rsp_rdata = 0.
- If ack and expiry coincide, ack wins.
- In RSP and IDLE, all DCR outputs are 0.
- RSP→IDLE on the rsp handshake. ack remaining high after the command drops is tolerated; IDLE keeps req_ready low until ack falls.
- The slave ack stays high until the command drops; the block never requires ack to fall while the command is high.

## Timing
- Reset values: every output is 0, the FSM is in IDLE, and the counter is 0. This applies asynchronously, including mid-transfer; any in-flight transfer and pending response are discarded.
- Request accepted at edge T:
  - The command is asserted from T+1.
  - Ack first sampled high at edge K: the command deasserts and rsp_valid asserts from K+1.
- Minimum request-to-response latency is 2 cycles; a new command can rise no earlier than 1 cycle after rsp handshake.
- Timeout: with no ack and no inhibit, the command is held for exactly TIMEOUT_CYCLES cycles, then rsp_valid is asserted with rsp_timeout.
- rsp_valid, rsp_rdata and rsp_timeout hold stable until the handshake. req_valid arriving during CMD/RSP is not accepted.

## Configuration
- AMIQ_DCR_MASTER_STATS_EN defined adds two outputs:
  - stat_xfer_cnt[15:0]: completed transfers.
  - stat_timeout_cnt[15:0]: timeouts.
  - Both increment on CMD→RSP, saturate at 16'hFFFF, and reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

## Structure
- Package amiq_dcr_pkg:
  - FSM state enum (IDLE/CMD/RSP).
  - Max width constants: address 32, min address 10, data 32, master ID 4.
- Sub-module amiq_dcr_timeout_cnt: load / decrement-enable / inhibit / zero-flag counter, instantiated once.

## Test plan
- Read 0x3A0, slave acks 3 cycles after the command rises with d_bus_in=0xDEADBEEF → read high for 3 cycles, d_bus_out=0, rsp_rdata=0xDEADBEEF, rsp_timeout=0.
- Write 0x010 with data 0x12345678, priv=1, id=5 → write, a_bus, d_bus_out, privileged and master_id stable until ack; rsp_rdata=0.
- TIMEOUT_CYCLES=8, no ack → command high exactly 8 cycles, rsp_timeout=1; repeat with timeout_wait high for 5 cycles → command high 13 cycles.
- Ack held high 4 cycles after the command drops while req_valid=1 → req_ready stays 0 until ack falls; the next command rises one cycle later.
- reset_n asserted mid-CMD → read/write and rsp_valid fall immediately; after release, req_ready=1 and no response is emitted.
- With AMIQ_DCR_MASTER_STATS_EN: 3 acked transfers plus 1 timeout → stat_xfer_cnt=4, stat_timeout_cnt=1.

Source files
------------

// File: rtl/amiq_dcr_pkg.sv
// Shared types and limits for the DCR master controller.
package amiq_dcr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    localparam int MAX_ADDR_WIDTH      = 32;
    localparam int MIN_ADDR_WIDTH      = 10;
    localparam int MAX_DATA_WIDTH      = 32;
    localparam int MAX_MASTER_ID_WIDTH = 4;

    // Counter width able to hold cycles-1; never below one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/amiq_dcr_timeout_cnt.sv
// Down-counter with load, decrement enable and inhibit; holds at zero.
module amiq_dcr_timeout_cnt
    import amiq_dcr_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec_en,
    input  logic             inhibit,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec_en && !inhibit && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/amiq_dcr_master_ctrl.sv
// DCR bus master: valid/ready request/response to DCR read/write transfers.
// Optional statistics counters enabled by defining AMIQ_DCR_MASTER_STATS_EN.
//
// state | meaning
// IDLE  | waiting for a request; ready only while ack is low
// CMD   | read or write strobe driven from captured request
// RSP   | response held until consumed
module amiq_dcr_master_ctrl
    import amiq_dcr_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MASTER_ID_WIDTH = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [ADDR_WIDTH-1:0]      req_addr,
    input  logic [DATA_WIDTH-1:0]      req_wdata,
    input  logic                       req_priv,
    input  logic [MASTER_ID_WIDTH-1:0] req_master_id,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_rdata,
    output logic                       rsp_timeout,
    output logic                       read,
    output logic                       write,
    output logic                       privileged,
    output logic [MASTER_ID_WIDTH-1:0] master_id,
    output logic [ADDR_WIDTH-1:0]      a_bus,
    output logic [DATA_WIDTH-1:0]      d_bus_out,
    input  logic                       timeout_wait,
    input  logic                       ack,
    input  logic [DATA_WIDTH-1:0]      d_bus_in
`ifdef AMIQ_DCR_MASTER_STATS_EN
    ,
    output logic [15:0]                stat_xfer_cnt,
    output logic [15:0]                stat_timeout_cnt
`endif
);

    localparam int              CNT_W    = cnt_width(TIMEOUT_CYCLES);
    localparam bit              TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] LOAD_VAL = TMO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_e                     state_q, state_d;
    logic                       ready_en_q;
    logic                       wr_q, priv_q;
    logic [ADDR_WIDTH-1:0]      addr_q;
    logic [DATA_WIDTH-1:0]      wdata_q;
    logic [MASTER_ID_WIDTH-1:0] mid_q;
    logic [DATA_WIDTH-1:0]      rdata_q;
    logic                       tmo_q;
    logic                       cnt_zero;
    logic                       in_cmd, accept, ack_done, expire;

    assign in_cmd    = (state_q == ST_CMD);
    assign req_ready = ready_en_q && (state_q == ST_IDLE) && !ack;
    assign accept    = req_valid && req_ready;
    assign ack_done  = in_cmd && ack;
    // timeout_wait also blocks expiry so an inhibited counter sitting at zero cannot fire
    assign expire    = TMO_EN && in_cmd && !ack && !timeout_wait && cnt_zero;

    amiq_dcr_timeout_cnt #(.WIDTH(CNT_W)) u_timeout_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (accept),
        .load_val (LOAD_VAL),
        .dec_en   (in_cmd && !ack),
        .inhibit  (timeout_wait),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)              state_d = ST_CMD;
            ST_CMD:  if (ack_done || expire)  state_d = ST_RSP;
            ST_RSP:  if (rsp_ready)           state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= 1'b0;
            priv_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mid_q   <= '0;
            rdata_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            if (accept) begin
                wr_q    <= req_write;
                priv_q  <= req_priv;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                mid_q   <= req_master_id;
            end
            if (ack_done) begin
                rdata_q <= wr_q ? '0 : d_bus_in;
                tmo_q   <= 1'b0;
            end else if (expire) begin
                rdata_q <= '0;
                tmo_q   <= 1'b1;
            end else if ((state_q == ST_RSP) && rsp_ready) begin
                rdata_q <= '0;
                tmo_q   <= 1'b0;
            end
        end
    end

    assign read        = in_cmd && !wr_q;
    assign write       = in_cmd && wr_q;
    assign privileged  = in_cmd && priv_q;
    assign master_id   = in_cmd ? mid_q : '0;
    assign a_bus       = in_cmd ? addr_q : '0;
    assign d_bus_out   = (in_cmd && wr_q) ? wdata_q : '0;
    assign rsp_valid   = (state_q == ST_RSP);
    assign rsp_rdata   = rdata_q;
    assign rsp_timeout = tmo_q;

`ifdef AMIQ_DCR_MASTER_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_xfer_cnt    <= '0;
            stat_timeout_cnt <= '0;
        end else begin
            if ((ack_done || expire) && (stat_xfer_cnt != 16'hFFFF)) begin
                stat_xfer_cnt <= stat_xfer_cnt + 16'd1;
            end
            if (expire && (stat_timeout_cnt != 16'hFFFF)) begin
                stat_timeout_cnt <= stat_timeout_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_amiq_dcr_master_ctrl.sv
// Self-checking bench for amiq_dcr_master_ctrl: vector table, directed corner cases, random model.
module tb_amiq_dcr_master_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int TC = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0, req_write = 1'b0, req_priv = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [IW-1:0] req_master_id = '0;
    logic          rsp_ready = 1'b0;
    logic          timeout_wait = 1'b0, ack = 1'b0;
    logic [DW-1:0] d_bus_in = '0;
    logic          req_ready, rsp_valid, rsp_timeout, read, write, privileged;
    logic [DW-1:0] rsp_rdata, d_bus_out;
    logic [IW-1:0] master_id;
    logic [AW-1:0] a_bus;
`ifdef AMIQ_DCR_MASTER_STATS_EN
    logic [15:0]   stat_xfer_cnt, stat_timeout_cnt;
`endif

    amiq_dcr_master_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASTER_ID_WIDTH(IW), .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_priv(req_priv),
        .req_master_id(req_master_id),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_timeout(rsp_timeout),
        .read(read), .write(write), .privileged(privileged), .master_id(master_id),
        .a_bus(a_bus), .d_bus_out(d_bus_out),
        .timeout_wait(timeout_wait), .ack(ack), .d_bus_in(d_bus_in)
`ifdef AMIQ_DCR_MASTER_STATS_EN
        , .stat_xfer_cnt(stat_xfer_cnt), .stat_timeout_cnt(stat_timeout_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int exp_xfer = 0;
    int exp_tmo  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          priv;
        logic [IW-1:0] id;
        int            ack_cyc;   // command cycle in which ack is raised; 0 = never
        logic [DW-1:0] dbin;
        int            wait_n;    // timeout_wait held for the first wait_n command cycles
        int            exp_cyc;
        logic [DW-1:0] exp_rdata;
        logic          exp_tmo;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input logic priv,
                                input logic [IW-1:0] id, input int ack_cyc,
                                input logic [DW-1:0] dbin, input int wait_n,
                                input int exp_cyc, input logic [DW-1:0] exp_rdata,
                                input logic exp_tmo);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.priv = priv; v.id = id;
        v.ack_cyc = ack_cyc; v.dbin = dbin; v.wait_n = wait_n;
        v.exp_cyc = exp_cyc; v.exp_rdata = exp_rdata; v.exp_tmo = exp_tmo;
        return v;
    endfunction

    task automatic do_xfer(input vec_t v, input string tag);
        int   guard;
        int   cyc;
        logic stable;
        @(negedge clk);
        req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
        req_priv = v.priv; req_master_id = v.id; rsp_ready = 1'b0;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, " accept"}, 64'(guard < 50), 64'd1);
        @(negedge clk);
        // scramble request inputs to show the command comes from captured values
        req_valid = 1'b0; req_write = ~v.wr; req_addr = $urandom; req_wdata = $urandom;
        req_priv = ~v.priv; req_master_id = ~v.id;
        cyc = 0;
        stable = 1'b1;
        while ((read || write) && cyc < 100) begin
            cyc++;
            if (read !== !v.wr || write !== v.wr || a_bus !== v.addr ||
                d_bus_out !== (v.wr ? v.wdata : '0) || privileged !== v.priv ||
                master_id !== v.id)
                stable = 1'b0;
            timeout_wait = (cyc <= v.wait_n);
            if (cyc == v.ack_cyc) begin
                ack = 1'b1;
                d_bus_in = v.dbin;
            end
            @(negedge clk);
        end
        ack = 1'b0; timeout_wait = 1'b0; d_bus_in = $urandom;
        check({tag, " cmd stable"}, 64'(stable), 64'd1);
        check({tag, " cmd cycles"}, 64'(cyc), 64'(v.exp_cyc));
        check({tag, " rsp_valid"}, 64'(rsp_valid), 64'd1);
        check({tag, " rsp_rdata"}, 64'(rsp_rdata), 64'(v.exp_rdata));
        check({tag, " rsp_timeout"}, 64'(rsp_timeout), 64'(v.exp_tmo));
        @(negedge clk);
        check({tag, " rsp hold"}, {rsp_valid, rsp_timeout, rsp_rdata},
              {1'b1, v.exp_tmo, v.exp_rdata});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, " idle outputs"},
              {rsp_valid, read, write, privileged, master_id, |a_bus, |d_bus_out}, 64'd0);
        exp_xfer++;
        if (v.exp_tmo) exp_tmo++;
    endtask

    vec_t vecs[8];

    initial begin
        int   guard;
        logic bad;
        vec_t v;
        int   lim;

        vecs[0] = mk(1'b0, 'h3A0, 'h0,        1'b0, 4'd0, 3, 'hDEADBEEF, 0,  3, 'hDEADBEEF, 1'b0);
        vecs[1] = mk(1'b1, 'h010, 'h12345678, 1'b1, 4'd5, 2, 'hFFFFFFFF, 0,  2, 'h0,        1'b0);
        vecs[2] = mk(1'b0, 'h155, 'h0,        1'b1, 4'hF, 0, 'h0,        0,  8, 'h0,        1'b1);
        vecs[3] = mk(1'b0, 'h2AA, 'h0,        1'b0, 4'd3, 0, 'h0,        5, 13, 'h0,        1'b1);
        vecs[4] = mk(1'b0, 'hFFFFFFFF, 'h0,   1'b0, 4'd1, 8, 'hA5A55A5A, 0,  8, 'hA5A55A5A, 1'b0);
        vecs[5] = mk(1'b1, 'h000, 'hCAFEF00D, 1'b0, 4'd2, 1, 'h00000001, 0,  1, 'h0,        1'b0);
        vecs[6] = mk(1'b0, 'h400, 'h0,        1'b0, 4'd7, 9, 'h00000011, 0,  8, 'h0,        1'b1);
        vecs[7] = mk(1'b0, 'h3FF, 'h0,        1'b1, 4'd9, 6, 'h0BADF00D, 3,  6, 'h0BADF00D, 1'b0);

        // reset state
        #12;
        check("reset outputs",
              {req_ready, rsp_valid, rsp_timeout, read, write, privileged, master_id,
               |a_bus, |d_bus_out, |rsp_rdata}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready after reset", 64'(req_ready), 64'd1);

        // reset in the middle of a command
        req_valid = 1'b1; req_write = 1'b0; req_addr = 'h123; req_priv = 1'b1; req_master_id = 4'd6;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        check("pre-reset read", 64'(read), 64'd1);
        #2 reset_n = 1'b0;
        #1 check("async reset cmd", {read, write, rsp_valid, req_ready, privileged, |a_bus}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rsp_ready = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid || read || write) bad = 1'b1;
        end
        rsp_ready = 1'b0;
        check("no rsp after reset", 64'(bad), 64'd0);
        check("ready after mid reset", 64'(req_ready), 64'd1);

        // vector table
        for (int i = 0; i < 8; i++) do_xfer(vecs[i], $sformatf("vec%0d", i));

        // ack held high after the command drops while a new request waits
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 'h100; rsp_ready = 1'b1;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        check("held-ack read up", 64'(read), 64'd1);
        ack = 1'b1; d_bus_in = 'h55;
        @(negedge clk);
        check("held-ack rsp", {rsp_valid, read, rsp_rdata}, {1'b1, 1'b0, 32'h55});
        req_valid = 1'b1; req_write = 1'b1; req_addr = 'h200; req_wdata = 'h77;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (req_ready || read || write) bad = 1'b1;
            @(negedge clk);
        end
        check("ready low while ack high", 64'(bad), 64'd0);
        ack = 1'b0;
        #1 check("ready after ack falls", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("next cmd one cycle later", {write, a_bus, d_bus_out}, {1'b1, 32'h200, 32'h77});
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("held-ack write rsp", {rsp_valid, rsp_timeout, rsp_rdata}, {1'b1, 1'b0, 32'h0});
        @(negedge clk);
        rsp_ready = 1'b0;
        check("held-ack rsp done", 64'(rsp_valid), 64'd0);
        exp_xfer += 2;

        // random transfers against a latency/outcome model
        for (int n = 0; n < 40; n++) begin
            v.wr = 1'($urandom); v.addr = $urandom; v.wdata = $urandom;
            v.priv = 1'($urandom); v.id = 4'($urandom); v.dbin = $urandom;
            v.ack_cyc = $urandom_range(0, 12);
            v.wait_n = $urandom_range(0, 3);
            lim = TC + v.wait_n;
            if (v.ack_cyc != 0 && v.ack_cyc <= lim) begin
                v.exp_cyc = v.ack_cyc;
                v.exp_rdata = v.wr ? '0 : v.dbin;
                v.exp_tmo = 1'b0;
            end else begin
                v.exp_cyc = lim;
                v.exp_rdata = '0;
                v.exp_tmo = 1'b1;
            end
            do_xfer(v, $sformatf("rnd%0d", n));
        end

`ifdef AMIQ_DCR_MASTER_STATS_EN
        check("stat_xfer_cnt", 64'(stat_xfer_cnt), 64'(exp_xfer));
        check("stat_timeout_cnt", 64'(stat_timeout_cnt), 64'(exp_tmo));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d",
                 n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
